// File: rtl/d_cache_control_nway_pkg.sv
// Shared cache geometry types and default widths for the lc3b data-cache controller.
package d_cache_control_nway_pkg;

    localparam int unsigned C_ADDR_WIDTH   = 16;
    localparam int unsigned C_OFFSET_WIDTH = 4;
    localparam int unsigned C_INDEX_WIDTH  = 3;
    localparam int unsigned C_TAG_WIDTH    = C_ADDR_WIDTH - C_INDEX_WIDTH - C_OFFSET_WIDTH;
    localparam int unsigned C_WAYS         = 4;

    typedef logic [C_TAG_WIDTH-1:0]   lc3b_c_tag;
    typedef logic [C_INDEX_WIDTH-1:0] lc3b_c_index;

endpackage

// File: rtl/d_cache_victim_sel.sv
// Combinational way selection: hit-way priority encoder and miss victim choice
// (lowest invalid way first, otherwise the PLRU candidate).
module d_cache_victim_sel
    import d_cache_control_nway_pkg::*;
#(
    parameter  int unsigned WAYS     = C_WAYS,
    localparam int unsigned WAY_BITS = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]     hit_vec,
    input  logic [WAYS-1:0]     valid_vec,
    input  logic [WAY_BITS-1:0] plru_victim,
    output logic                hit_c,
    output logic [WAY_BITS-1:0] hit_way_c,
    output logic [WAY_BITS-1:0] victim_c
);

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit_c     = |hit_vec;
        hit_way_c = '0;
        victim_c  = plru_victim;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_way_c = WAY_BITS'(i);
            end
            if (!valid_vec[i]) begin
                victim_c = WAY_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/d_cache_control_nway.sv
// N-way set-associative write-back/write-allocate data-cache controller for lc3b.
// Optional performance counters are enabled by defining D_CACHE_PERF_EN.
module d_cache_control_nway
    import d_cache_control_nway_pkg::*;
#(
    parameter  int unsigned WAYS         = C_WAYS,
    parameter  int unsigned ADDR_WIDTH   = C_ADDR_WIDTH,
    parameter  int unsigned OFFSET_WIDTH = C_OFFSET_WIDTH,
    parameter  int unsigned INDEX_WIDTH  = C_INDEX_WIDTH,
    parameter  int unsigned TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
    localparam int unsigned WAY_BITS     = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic                  mem_resp,
    input  logic [WAYS-1:0]       hit_vec,
    input  logic [WAYS-1:0]       valid_vec,
    input  logic [WAYS-1:0]       dirty_vec,
    input  logic [WAY_BITS-1:0]   plru_victim,
    input  logic [TAG_WIDTH-1:0]  victim_tag,
    output logic [WAY_BITS-1:0]   victim_way,
    output logic [WAYS-1:0]       ld_data,
    output logic                  data_sel,
    output logic [WAYS-1:0]       ld_tag,
    output logic [WAYS-1:0]       ld_valid,
    output logic [WAYS-1:0]       ld_dirty,
    output logic                  dirty_in,
    output logic                  ld_lru,
    output logic [WAY_BITS-1:0]   lru_way,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic                  pmem_read,
    output logic                  pmem_write,
    input  logic                  pmem_resp
`ifdef D_CACHE_PERF_EN
    ,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count,
    output logic [15:0]           wb_count
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [WAY_BITS-1:0]   victim_q;
    logic [ADDR_WIDTH-1:0] miss_addr_q;
    logic                  miss_start_c;
    logic                  wb_done_c;
    logic                  hit_c;
    logic [WAY_BITS-1:0]   hit_way_c;
    logic [WAY_BITS-1:0]   victim_c;
    logic [WAYS-1:0]       victim_onehot_c;
    logic [WAYS-1:0]       hit_onehot_c;

    d_cache_victim_sel #(
        .WAYS (WAYS)
    ) u_victim_sel (
        .hit_vec     (hit_vec),
        .valid_vec   (valid_vec),
        .plru_victim (plru_victim),
        .hit_c       (hit_c),
        .hit_way_c   (hit_way_c),
        .victim_c    (victim_c)
    );

    assign victim_onehot_c = WAYS'(1) << victim_q;
    assign hit_onehot_c    = WAYS'(1) << hit_way_c;
    assign victim_way      = victim_q;

    // State, latched victim and line-aligned miss address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            victim_q    <= '0;
            miss_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start_c) begin
                victim_q    <= victim_c;
                miss_addr_q <= {mem_address[ADDR_WIDTH-1:OFFSET_WIDTH], OFFSET_WIDTH'(0)};
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        miss_start_c = 1'b0;
        wb_done_c    = 1'b0;
        mem_resp     = 1'b0;
        ld_data      = '0;
        data_sel     = 1'b0;
        ld_tag       = '0;
        ld_valid     = '0;
        ld_dirty     = '0;
        dirty_in     = 1'b0;
        ld_lru       = 1'b0;
        lru_way      = '0;
        pmem_address = mem_address;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    if (hit_c) begin
                        mem_resp = 1'b1;
                        ld_lru   = 1'b1;
                        lru_way  = hit_way_c;
                        // A write wins over a simultaneous read.
                        if (mem_write) begin
                            ld_data  = hit_onehot_c;
                            data_sel = 1'b1;
                            ld_dirty = hit_onehot_c;
                            dirty_in = 1'b1;
                        end
                    end else begin
                        miss_start_c = 1'b1;
                        if (valid_vec[victim_c] && dirty_vec[victim_c]) begin
                            state_d = WRITEBACK;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {victim_tag, miss_addr_q[OFFSET_WIDTH +: INDEX_WIDTH],
                                OFFSET_WIDTH'(0)};
                if (pmem_resp) begin
                    wb_done_c = 1'b1;
                    ld_dirty  = victim_onehot_c;
                    state_d   = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = miss_addr_q;
                if (pmem_resp) begin
                    ld_data  = victim_onehot_c;
                    ld_tag   = victim_onehot_c;
                    ld_valid = victim_onehot_c;
                    ld_dirty = victim_onehot_c;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef D_CACHE_PERF_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (mem_resp && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss_start_c && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
            if (wb_done_c && (wb_count != 16'hFFFF)) begin
                wb_count <= wb_count + 16'd1;
            end
        end
    end
`endif

endmodule
